// File: rtl/fifo.sv
// Synchronous single-clock FIFO with a registered read port and occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DIN,
   input  logic             WE,
   input  logic             RE,
   output logic [WIDTH-1:0] DOUT,
   output logic             NOT_EMPTY,
   output logic             FULL
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             wr_accept;
   logic             rd_accept;
   logic             is_empty;
   logic             is_full;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == FULL_CNT);

   // A read frees a slot on the same edge, so a write into a full FIFO is accepted alongside it.
   always_comb begin
      rd_accept = RE && !is_empty;
      wr_accept = WE && (!is_full || rd_accept);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;

      if (wr_accept) begin
         wr_ptr_d = next_ptr(wr_ptr_q);
      end

      if (rd_accept) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
         dout_d   = mem[rd_ptr_q];
      end

      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   // Storage is not reset; the zeroed count keeps stale words unreachable.
   always_ff @(posedge CLK) begin
      if (wr_accept && !RESET) begin
         mem[wr_ptr_q] <= DIN;
      end
   end

   assign DOUT      = dout_q;
   assign NOT_EMPTY = !is_empty;
   assign FULL      = is_full;

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo at WIDTH=8, DEPTH=32.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;

   logic             CLK;
   logic             RESET;
   logic [WIDTH-1:0] DIN;
   logic             WE;
   logic             RE;
   logic [WIDTH-1:0] DOUT;
   logic             NOT_EMPTY;
   logic             FULL;

   int checkCount;
   int failCount;

   fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .DIN       (DIN),
      .WE        (WE),
      .RE        (RE),
      .DOUT      (DOUT),
      .NOT_EMPTY (NOT_EMPTY),
      .FULL      (FULL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, then land just after the rising edge.
   task automatic applyStimulus(input logic we, input logic re, input logic [WIDTH-1:0] din);
      WE  = we;
      RE  = re;
      DIN = din;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int modelCount;
      int nextWr;
      int nextRd;
      int cycles;
      logic reOn;
      logic rdAcc;
      logic wrAcc;
      logic doWe;

      checkCount = 0;
      failCount  = 0;
      WE    = 1'b0;
      RE    = 1'b0;
      DIN   = '0;
      RESET = 1'b1;

      // Reset then idle
      #1;
      checkOutput("reset_dout", int'(DOUT), 0);
      checkOutput("reset_not_empty", int'(NOT_EMPTY), 0);
      checkOutput("reset_full", int'(FULL), 0);
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      RESET = 1'b0;
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("idle_dout", int'(DOUT), 0);
      checkOutput("idle_not_empty", int'(NOT_EMPTY), 0);
      checkOutput("idle_full", int'(FULL), 0);

      $display("[TB] fill 0..31");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, WIDTH'(i));
         if (i == 0) begin
            checkOutput("fill_first_not_empty", int'(NOT_EMPTY), 1);
            checkOutput("fill_first_full", int'(FULL), 0);
         end
         if (i == DEPTH - 2) begin
            checkOutput("fill_31_full", int'(FULL), 0);
         end
      end
      checkOutput("fill_32_full", int'(FULL), 1);
      checkOutput("fill_32_not_empty", int'(NOT_EMPTY), 1);
      checkOutput("fill_32_dout", int'(DOUT), 0);

      applyStimulus(1'b1, 1'b0, 8'd99);
      checkOutput("drop_full", int'(FULL), 1);
      checkOutput("drop_dout", int'(DOUT), 0);

      $display("[TB] read+write while full");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, WIDTH'(DEPTH + i));
         checkOutput("full_rw_dout", int'(DOUT), i);
         checkOutput("full_rw_full", int'(FULL), 1);
      end

      // Contents are now 8..39; the dropped 99 must never appear
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, '0);
         checkOutput("drain_dout", int'(DOUT), 8 + i);
         if (i == 0) begin
            checkOutput("drain_first_full", int'(FULL), 0);
         end
      end
      checkOutput("drain_not_empty", int'(NOT_EMPTY), 0);
      checkOutput("drain_full", int'(FULL), 0);

      $display("[TB] stream 0..255");
      modelCount = 0;
      nextWr     = 0;
      nextRd     = 0;
      reOn       = 1'b0;
      cycles     = 0;
      while ((nextWr < 256 || modelCount > 0) && cycles < 2000) begin
         doWe = (nextWr < 256);
         applyStimulus(doWe, reOn, WIDTH'(nextWr));
         rdAcc = reOn && (modelCount > 0);
         wrAcc = doWe && ((modelCount < DEPTH) || rdAcc);
         if (wrAcc) nextWr++;
         if (rdAcc) begin
            checkOutput("stream_dout", int'(DOUT), nextRd);
            nextRd++;
         end
         modelCount = modelCount + (wrAcc ? 1 : 0) - (rdAcc ? 1 : 0);
         checkOutput("stream_full", int'(FULL), (modelCount == DEPTH) ? 1 : 0);
         if (modelCount == DEPTH) reOn = 1'b1;
         cycles++;
      end
      checkOutput("stream_done_in_budget", (cycles < 2000) ? 1 : 0, 1);
      checkOutput("stream_end_not_empty", int'(NOT_EMPTY), 0);
      checkOutput("stream_end_dout", int'(DOUT), 255);

      // Read when empty
      applyStimulus(1'b0, 1'b1, '0);
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("empty_read_dout", int'(DOUT), 255);
      checkOutput("empty_read_not_empty", int'(NOT_EMPTY), 0);

      // Simultaneous read+write when empty: only the write lands, no bypass
      applyStimulus(1'b1, 1'b1, 8'h5A);
      checkOutput("empty_rw_dout", int'(DOUT), 255);
      checkOutput("empty_rw_not_empty", int'(NOT_EMPTY), 1);
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("empty_rw_read_dout", int'(DOUT), 'h5A);
      checkOutput("empty_rw_read_not_empty", int'(NOT_EMPTY), 0);

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b1, 1'b0, WIDTH'(100 + i));
      end
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("pre_reset_dout", int'(DOUT), 100);
      checkOutput("pre_reset_not_empty", int'(NOT_EMPTY), 1);
      WE = 1'b0;
      RE = 1'b0;
      #2;
      RESET = 1'b1;
      #1;
      checkOutput("async_reset_dout", int'(DOUT), 0);
      checkOutput("async_reset_not_empty", int'(NOT_EMPTY), 0);
      checkOutput("async_reset_full", int'(FULL), 0);
      applyStimulus(1'b1, 1'b1, 8'h77);
      checkOutput("in_reset_not_empty", int'(NOT_EMPTY), 0);
      checkOutput("in_reset_dout", int'(DOUT), 0);
      WE = 1'b0;
      RE = 1'b0;
      #2;
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      applyStimulus(1'b1, 1'b0, 8'hAB);
      checkOutput("post_reset_not_empty", int'(NOT_EMPTY), 1);
      checkOutput("post_reset_dout", int'(DOUT), 0);
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("post_reset_read_dout", int'(DOUT), 'hAB);
      checkOutput("post_reset_read_not_empty", int'(NOT_EMPTY), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
